// File: rtl/oflow_registration_score_board.sv
// Registration score-board responder: latches one set of score-calc results,
// resolves per-ID claims one PE per cycle, and answers with a done pulse.
module oflow_registration_score_board #(
  parameter int PE_NUM  = 8,
  parameter int SCORE_W = 16,
  parameter int ID_W    = 8,
  parameter int SET_W   = 6,
  parameter int FRAME_W = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_score_board,
  input  logic [FRAME_W-1:0]                frame_num,
  input  logic [SET_W-1:0]                  counter_of_sets,
  input  logic                              clear_board,
  input  logic [PE_NUM-1:0]                 score_valid,
  input  logic [PE_NUM*SCORE_W-1:0]         score_data,
  input  logic [PE_NUM*ID_W-1:0]            score_id,
  input  logic [ID_W-1:0]                   rd_id,
  output logic                              rd_valid,
  output logic [SCORE_W-1:0]                rd_score,
  output logic [SET_W+$clog2(PE_NUM)-1:0]   rd_owner,
  output logic                              done_score_board,
  output logic                              busy,
  output logic [ID_W-1:0]                   next_id,
  output logic                              id_overflow,
  output logic                              protocol_err
);

  localparam int PE_W  = $clog2(PE_NUM);
  localparam int OWN_W = SET_W + PE_W;
  localparam int DEPTH = 2 ** ID_W;
  localparam logic [ID_W-1:0] ID_MAX  = '1;
  localparam logic [PE_W-1:0] PE_LAST = PE_W'(PE_NUM - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic                first_mode;
  logic [SET_W-1:0]    set_q;
  logic [PE_NUM-1:0]   valid_q;
  logic [SCORE_W-1:0]  data_q [PE_NUM];
  logic [ID_W-1:0]     id_q   [PE_NUM];
  logic [PE_W-1:0]     pe_idx;

  logic [DEPTH-1:0]    tbl_valid;
  logic [SCORE_W-1:0]  tbl_score [DEPTH];
  logic [OWN_W-1:0]    tbl_owner [DEPTH];

  logic                accept, cur_valid, alloc_req, alloc_ok, claim, wr_en;
  logic [SCORE_W-1:0]  cur_score, wr_score;
  logic [ID_W-1:0]     cur_id, wr_addr;
  logic [OWN_W-1:0]    wr_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_score_board) state_nxt = LATCH;
      LATCH:   state_nxt = SCAN;
      SCAN:    if (pe_idx == PE_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy             = (state != IDLE);
  assign done_score_board = (state == DONE);
  assign accept           = (state == IDLE) && start_score_board;

  // The entry under test is compared against the registered table, so a
  // same-cycle write is only visible from the next cycle on.
  always_comb begin
    cur_valid = valid_q[pe_idx];
    cur_score = data_q[pe_idx];
    cur_id    = id_q[pe_idx];
    alloc_req = (state == SCAN) && first_mode && cur_valid;
    alloc_ok  = alloc_req && (next_id != ID_MAX);
    claim     = (state == SCAN) && !first_mode && cur_valid &&
                (!tbl_valid[cur_id] || (cur_score < tbl_score[cur_id]));
    wr_en     = alloc_ok || claim;
    wr_addr   = first_mode ? next_id : cur_id;
    wr_score  = first_mode ? '0 : cur_score;
    wr_owner  = {set_q, pe_idx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_mode   <= 1'b0;
      set_q        <= '0;
      valid_q      <= '0;
      pe_idx       <= '0;
      next_id      <= '0;
      id_overflow  <= 1'b0;
      protocol_err <= 1'b0;
      tbl_valid    <= '0;
      for (int i = 0; i < PE_NUM; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      if ((state != IDLE) && (start_score_board || clear_board))
        protocol_err <= 1'b1;
      // Clear is applied before a simultaneous start; no table write can
      // happen in IDLE, so the two never collide.
      if ((state == IDLE) && clear_board) begin
        tbl_valid <= '0;
        next_id   <= '0;
      end
      if (accept) begin
        first_mode <= (frame_num == '0);
        set_q      <= counter_of_sets;
        valid_q    <= score_valid;
        for (int i = 0; i < PE_NUM; i++) begin
          data_q[i] <= score_data[i*SCORE_W +: SCORE_W];
          id_q[i]   <= score_id[i*ID_W +: ID_W];
        end
      end
      if (state == LATCH) pe_idx <= '0;
      if (state == SCAN)  pe_idx <= pe_idx + 1'b1;
      if (wr_en) tbl_valid[wr_addr] <= 1'b1;
      if (alloc_ok) next_id <= next_id + 1'b1;
      if (alloc_req && !alloc_ok) id_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_score[wr_addr] <= wr_score;
      tbl_owner[wr_addr] <= wr_owner;
    end
  end

  // Score and owner of unclaimed entries read as zero.
  always_comb begin
    rd_valid = tbl_valid[rd_id];
    rd_score = rd_valid ? tbl_score[rd_id] : '0;
    rd_owner = rd_valid ? tbl_owner[rd_id] : '0;
  end

endmodule

// File: tb/tb_oflow_registration_score_board.sv
// Self-checking bench for oflow_registration_score_board: table-driven conflict
// vectors, directed corner sequences and randomized sets against a table model.
module tb_oflow_registration_score_board;

  localparam int PE_NUM = 8, SCORE_W = 16, ID_W = 8, SET_W = 6, FRAME_W = 16;
  localparam int OWN_W = SET_W + $clog2(PE_NUM);
  localparam int DEPTH = 2 ** ID_W;

  logic clk = 1'b0, reset = 1'b1;
  logic start_score_board = 1'b0, clear_board = 1'b0;
  logic [FRAME_W-1:0] frame_num = '0;
  logic [SET_W-1:0] counter_of_sets = '0;
  logic [PE_NUM-1:0] score_valid = '0;
  logic [PE_NUM*SCORE_W-1:0] score_data = '0;
  logic [PE_NUM*ID_W-1:0] score_id = '0;
  logic [ID_W-1:0] rd_id = '0;
  logic rd_valid, done_score_board, busy, id_overflow, protocol_err;
  logic [SCORE_W-1:0] rd_score;
  logic [OWN_W-1:0] rd_owner;
  logic [ID_W-1:0] next_id;

  oflow_registration_score_board #(
    .PE_NUM(PE_NUM), .SCORE_W(SCORE_W), .ID_W(ID_W), .SET_W(SET_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .reset(reset), .start_score_board(start_score_board),
    .frame_num(frame_num), .counter_of_sets(counter_of_sets), .clear_board(clear_board),
    .score_valid(score_valid), .score_data(score_data), .score_id(score_id),
    .rd_id(rd_id), .rd_valid(rd_valid), .rd_score(rd_score), .rd_owner(rd_owner),
    .done_score_board(done_score_board), .busy(busy), .next_id(next_id),
    .id_overflow(id_overflow), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  // Reference model: the claim table as plain arrays.
  bit m_valid [DEPTH];
  int m_score [DEPTH];
  int m_owner [DEPTH];
  int m_next;
  bit m_ovf, m_perr;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_next = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_ovf = 1'b0;
    m_perr = 1'b0;
  endfunction

  function automatic void model_set(bit first, int set, logic [PE_NUM-1:0] mask,
                                    logic [PE_NUM*SCORE_W-1:0] data,
                                    logic [PE_NUM*ID_W-1:0] ids);
    for (int p = 0; p < PE_NUM; p++) begin
      int sc, id;
      if (!mask[p]) continue;
      sc = int'(data[p*SCORE_W +: SCORE_W]);
      id = int'(ids[p*ID_W +: ID_W]);
      if (first) begin
        if (m_next == DEPTH - 1) m_ovf = 1'b1;
        else begin
          m_valid[m_next] = 1'b1;
          m_score[m_next] = 0;
          m_owner[m_next] = set * PE_NUM + p;
          m_next++;
        end
      end else if (!m_valid[id] || sc < m_score[id]) begin
        m_valid[id] = 1'b1;
        m_score[id] = sc;
        m_owner[id] = set * PE_NUM + p;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkEntry(input int id);
    rd_id = ID_W'(id);
    @(negedge clk);
    checkOutput($sformatf("rd_valid[%0d]", id), 32'(rd_valid), 32'(m_valid[id]));
    if (m_valid[id]) begin
      checkOutput($sformatf("rd_score[%0d]", id), 32'(rd_score), m_score[id]);
      checkOutput($sformatf("rd_owner[%0d]", id), 32'(rd_owner), m_owner[id]);
    end
  endtask

  task automatic checkState();
    checkOutput("next_id", 32'(next_id), m_next);
    checkOutput("id_overflow", 32'(id_overflow), 32'(m_ovf));
    checkOutput("protocol_err", 32'(protocol_err), 32'(m_perr));
  endtask

  // Starts one set at a negedge, optionally injects an illegal start/clear in
  // a given busy cycle, and returns at the negedge of cycle 11 (IDLE).
  task automatic applyStimulus(input bit clr, input logic [FRAME_W-1:0] frame,
                               input logic [SET_W-1:0] set, input logic [PE_NUM-1:0] mask,
                               input logic [PE_NUM*SCORE_W-1:0] data,
                               input logic [PE_NUM*ID_W-1:0] ids,
                               input int inj_start, input int inj_clear);
    int done_cycle = 0, done_cnt = 0, busy_err = 0;
    clear_board = clr;
    start_score_board = 1'b1;
    frame_num = frame;
    counter_of_sets = set;
    score_valid = mask;
    score_data = data;
    score_id = ids;
    if (clr) model_clear();
    model_set(frame == '0, int'(set), mask, data, ids);
    if (inj_start > 0 || inj_clear > 0) m_perr = 1'b1;
    @(negedge clk);
    start_score_board = 1'b0;
    clear_board = 1'b0;
    score_valid = PE_NUM'($urandom);
    score_data = {4{$urandom()}};
    score_id = {2{$urandom()}};
    counter_of_sets = SET_W'($urandom);
    frame_num = 16'd0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done_score_board) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = cyc;
      end
      if (!busy) busy_err++;
      start_score_board = (cyc == inj_start);
      clear_board = (cyc == inj_clear);
      @(negedge clk);
    end
    start_score_board = 1'b0;
    clear_board = 1'b0;
    checkOutput("done_cycle", done_cycle, 10);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("busy_window_gaps", busy_err, 0);
    checkOutput("idle_after_done", {30'd0, busy, done_score_board}, 0);
  endtask

  task automatic clearTable();
    clear_board = 1'b1;
    model_clear();
    @(negedge clk);
    clear_board = 1'b0;
  endtask

  typedef struct {
    logic [SET_W-1:0]   set;
    logic [PE_NUM-1:0]  mask;
    logic [ID_W-1:0]    id;
    logic [SCORE_W-1:0] score;
    logic [ID_W-1:0]    probe;
    bit                 exp_valid;
    logic [SCORE_W-1:0] exp_score;
    logic [OWN_W-1:0]   exp_owner;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [PE_NUM*SCORE_W-1:0] d;
    logic [PE_NUM*ID_W-1:0] ids;

    // Every valid PE of a vector carries the same id and score.
    vecs[0] = '{6'd0, 8'h04, 8'd7,  16'd40,  8'd7, 1'b1, 16'd40,  9'd2};
    vecs[1] = '{6'd1, 8'h01, 8'd7,  16'd25,  8'd7, 1'b1, 16'd25,  9'd8};
    vecs[2] = '{6'd2, 8'h01, 8'd7,  16'd25,  8'd7, 1'b1, 16'd25,  9'd8};
    vecs[3] = '{6'd3, 8'h20, 8'd7,  16'd30,  8'd7, 1'b1, 16'd25,  9'd8};
    vecs[4] = '{6'd4, 8'h08, 8'd9,  16'd100, 8'd9, 1'b1, 16'd100, 9'd35};
    vecs[5] = '{6'd5, 8'h00, 8'd9,  16'd1,   8'd9, 1'b1, 16'd100, 9'd35};
    vecs[6] = '{6'd6, 8'h80, 8'd9,  16'd99,  8'd9, 1'b1, 16'd99,  9'd55};
    vecs[7] = '{6'd7, 8'h12, 8'd20, 16'd50,  8'd20, 1'b1, 16'd50, 9'd57};

    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done_score_board), 0);
    checkOutput("reset_next_id", 32'(next_id), 0);
    checkOutput("reset_flags", {30'd0, id_overflow, protocol_err}, 0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    reset = 1'b0;

    // First frame, clear and start on the same edge.
    applyStimulus(1'b1, 16'd0, 6'd0, 8'h0F, '0, '0, 0, 0);
    checkOutput("ff_next_id", 32'(next_id), 4);
    for (int i = 0; i < 4; i++) begin
      rd_id = ID_W'(i);
      @(negedge clk);
      checkOutput($sformatf("ff_valid[%0d]", i), 32'(rd_valid), 1);
      checkOutput($sformatf("ff_owner[%0d]", i), 32'(rd_owner), i);
      checkOutput($sformatf("ff_score[%0d]", i), 32'(rd_score), 0);
    end
    rd_id = 8'd4;
    @(negedge clk);
    checkOutput("ff_valid[4]", 32'(rd_valid), 0);

    // Conflict resolution vectors.
    clearTable();
    checkState();
    for (int v = 0; v < 8; v++) begin
      d = {PE_NUM{vecs[v].score}};
      ids = {PE_NUM{vecs[v].id}};
      applyStimulus(1'b0, 16'd5, vecs[v].set, vecs[v].mask, d, ids, 0, 0);
      rd_id = vecs[v].probe;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(vecs[v].exp_valid));
      checkOutput($sformatf("vec%0d_score", v), 32'(rd_score), 32'(vecs[v].exp_score));
      checkOutput($sformatf("vec%0d_owner", v), 32'(rd_owner), 32'(vecs[v].exp_owner));
    end

    // Illegal start in busy cycle 3 and clear during SCAN are both ignored.
    applyStimulus(1'b0, 16'd5, 6'd10, 8'h01, {PE_NUM{16'd5}}, {PE_NUM{8'd30}}, 3, 5);
    checkOutput("perr_set", 32'(protocol_err), 1);
    rd_id = 8'd30;
    @(negedge clk);
    checkOutput("perr_rd30_score", 32'(rd_score), 5);
    checkOutput("perr_rd30_owner", 32'(rd_owner), 80);
    rd_id = 8'd7;
    @(negedge clk);
    checkOutput("perr_rd7_kept", 32'(rd_valid), 1);
    checkOutput("perr_rd7_score", 32'(rd_score), 25);
    checkState();

    // Randomized sets against the model.
    clearTable();
    for (int s = 0; s < 20; s++) begin
      for (int p = 0; p < PE_NUM; p++) begin
        d[p*SCORE_W +: SCORE_W] = SCORE_W'($urandom_range(0, 7));
        ids[p*ID_W +: ID_W] = ID_W'($urandom_range(0, 15));
      end
      applyStimulus(1'b0, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 999)),
                    SET_W'(s), PE_NUM'($urandom), d, ids, 0, 0);
      checkState();
      for (int i = 0; i < 16; i++) checkEntry(i);
    end

    // Allocation saturation.
    clearTable();
    for (int s = 0; s < 31; s++) applyStimulus(1'b0, 16'd0, SET_W'(s), 8'hFF, '0, '0, 0, 0);
    applyStimulus(1'b0, 16'd0, 6'd31, 8'h3F, '0, '0, 0, 0);
    checkOutput("ovf_pre_next_id", 32'(next_id), 254);
    checkOutput("ovf_pre_flag", 32'(id_overflow), 0);
    applyStimulus(1'b0, 16'd0, 6'd33, 8'h07, '0, '0, 0, 0);
    checkOutput("ovf_next_id", 32'(next_id), 255);
    checkOutput("ovf_flag", 32'(id_overflow), 1);
    checkEntry(253);
    checkEntry(254);
    checkEntry(255);
    rd_id = 8'd254;
    @(negedge clk);
    checkOutput("ovf_rd254_owner", 32'(rd_owner), 264);

    // Reset while scanning PE 4.
    start_score_board = 1'b1;
    frame_num = 16'd5;
    counter_of_sets = 6'd1;
    score_valid = 8'hFF;
    @(negedge clk);
    start_score_board = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_done", 32'(done_score_board), 0);
    rd_id = 8'd7;
    #1;
    checkOutput("rst_mid_rd7", 32'(rd_valid), 0);
    rd_id = 8'd30;
    #1;
    checkOutput("rst_mid_rd30", 32'(rd_valid), 0);
    checkOutput("rst_mid_flags", {30'd0, id_overflow, protocol_err}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 16'd0, 6'd2, 8'h01, '0, '0, 0, 0);
    checkState();
    checkEntry(0);
    checkEntry(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/oflow_registration_score_board.md
Name: oflow_registration_score_board

Overview:
- Responder side of the registration score-board handshake: accepts a one-cycle start_score_board per set and processes that set's score-calc results.
- Resolves ID conflicts across sets and answers with a one-cycle done_score_board.
- Keeps a per-ID claim table: best score and owning (set, PE) slot. Registration reads final assignments from it after the last set of a frame.
- In frame 0 there is no previous frame, so it allocates fresh IDs instead of matching.

Parameters:
- PE_NUM, 8, objects (PEs) per set
- SCORE_W, 16, score width; lower score = better match
- ID_W, 8, ID width; table depth 2^ID_W
- SET_W, 6, set counter width
- FRAME_W, 16, frame number width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_score_board  in  1  one-cycle start for the current set
- frame_num  in  FRAME_W  current frame; 0 selects first-frame allocation
- counter_of_sets  in  SET_W  index of the set being processed
- clear_board  in  1  invalidates the table and zeroes next_id; new frame
- score_valid  in  PE_NUM  per-PE object-present mask
- score_data  in  PE_NUM*SCORE_W  per-PE best score; PE i at [i*SCORE_W +: SCORE_W]
- score_id  in  PE_NUM*ID_W  per-PE matched previous-frame ID
- rd_id  in  ID_W  table read address
- rd_valid  out  1  entry claimed
- rd_score  out  SCORE_W  entry score
- rd_owner  out  SET_W+$clog2(PE_NUM)  owner as {set, pe}
- done_score_board  out  1  one-cycle completion pulse
- busy  out  1  high from LATCH through DONE
- next_id  out  ID_W  next free ID for first-frame allocation
- id_overflow  out  1  sticky; allocation requested at saturation
- protocol_err  out  1  sticky; start or clear_board while busy

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; every table valid bit 0; latched inputs 0.
- IDLE -> LATCH on start_score_board.
  - In the same edge, capture frame_num==0 (first_mode), counter_of_sets, score_valid, score_data and score_id into internal registers.
  - The score-calc inputs may change after that edge.
- LATCH -> SCAN. Clear pe_idx to 0.
- SCAN: process one PE per cycle, pe_idx = 0..PE_NUM-1. An invalid PE still consumes its cycle.
  - first_mode, valid PE:
    - Write table[next_id] = {valid=1, score=0, owner={set, pe_idx}}.
    - next_id increments.
    - If next_id == 2^ID_W-1 when an allocation is requested: no write, next_id holds, id_overflow sets.
  - Normal mode, valid PE, id = score_id[pe_idx]:
    - Overwrite the entry when !table[id].valid, or when score < table[id].score (strict).
    - On a tie or higher score the existing claim stays, so an earlier set or lower PE index wins.
  - After pe_idx = PE_NUM-1, go to DONE.
- DONE: done_score_board=1 for exactly one cycle, then IDLE.
- Fixed latency: with start sampled at edge 0, done_score_board is high in cycle PE_NUM+2, i.e. 10 cycles for PE_NUM=8. busy is high over the same window, ending with DONE.
- start_score_board in IDLE during the DONE cycle's following edge is accepted. Back-to-back sets therefore need no idle gap beyond DONE.
- start_score_board while busy: ignored and sets protocol_err.
- clear_board:
  - Honoured only in IDLE: all valid bits clear and next_id=0 on the next edge.
  - While busy: ignored and sets protocol_err.
  - Simultaneous with start in IDLE: clear applies first, then the set is latched into the cleared table (same edge).
- Read port: combinational from the table and usable in any state. A read of the entry being written in the current cycle returns the pre-write value.
- Sticky flags clear only on reset.
- Reset mid-SCAN: immediate return to IDLE, table invalid, no done pulse.

Test Plan:
- First frame: clear_board, then start with frame_num=0, score_valid=8'h0F, one set -> done at cycle 10; next_id=4; rd_id 0..3 valid with owner {0,0..3}; rd_id 4 invalid.
- Conflict: frame_num=5, set0 PE2 id=7 score=40, then set1 PE0 id=7 score=25 -> table[7]={score 25, owner {1,0}}; tie set2 score=25 -> owner unchanged.
- Invalid skip: score_valid=8'h00 -> no table change; done still at exactly cycle 10.
- Protocol: start at cycle 3 of busy, and clear_board during SCAN -> both ignored; protocol_err=1; table and timing unaffected.
- Overflow: preload next_id to 254 via 254 first-frame allocations, then set with 3 valid PEs -> id 254 written; 2 requests dropped; next_id=255; id_overflow=1.
- Reset at pe_idx=4 -> busy=0 and done=0 immediately; all rd_valid=0; a fresh start works normally.
